// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED driver with a shared tick prescaler.
// Each channel is written to OFF / ON / BLINK / ONESHOT through a one-cycle
// write port. Optional brightness PWM is built when LED_BLINK_PWM_EN is
// defined; without it the duty input is ignored and no PWM state exists.
//
// Write handshake: i_wr_en is a single-cycle strobe with no back-pressure.
// A write is accepted when i_wr_ch < N_CH, and o_wr_ack pulses for the one
// cycle after the accepting edge. Writes to other channel numbers are dropped
// silently.
module led_blink_multi #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int PER_W   = 16,
  parameter int PWM_W   = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [CH_W-1:0]  i_wr_ch,
  input  logic [1:0]       i_wr_mode,
  input  logic [PER_W-1:0] i_wr_half,
  input  logic [PWM_W-1:0] i_wr_duty,
  output logic             o_wr_ack,
  output logic             o_tick,
  output logic [N_CH-1:0]  o_led
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_tick;
  logic             r_ack;
  logic [N_CH-1:0]  r_led;

  // Per-channel state: r_mode is each channel's state register.
  mode_t            r_mode  [N_CH];
  logic [PER_W-1:0] r_half  [N_CH];
  logic [PER_W-1:0] r_cnt   [N_CH];
  logic             r_phase [N_CH];

  mode_t            w_mode_nxt  [N_CH];
  logic [PER_W-1:0] w_half_nxt  [N_CH];
  logic [PER_W-1:0] w_cnt_nxt   [N_CH];
  logic             w_phase_nxt [N_CH];
  logic [N_CH-1:0]  w_raw;
  logic [N_CH-1:0]  w_led_nxt;
  logic             w_wr_ok;

  assign w_wr_ok = i_wr_en && (int'(i_wr_ch) < N_CH);

`ifdef LED_BLINK_PWM_EN
  logic [PWM_W-1:0] r_duty     [N_CH];
  logic [PWM_W-1:0] w_duty_nxt [N_CH];
  logic [PWM_W-1:0] r_pwm_cnt;

  // Free-running PWM phase counter shared by all channels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pwm_cnt <= '0;
    else          r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
  end
`else
  logic w_unused_duty;
  assign w_unused_duty = ^i_wr_duty;
`endif

  // Prescaler: wrap at DIV-1 and register the tick for the following cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= (r_pre_cnt == PRE_W'(DIV - 1));
      if (r_pre_cnt == PRE_W'(DIV - 1)) r_pre_cnt <= '0;
      else                              r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  // Channel next-state: a write to a channel overrides that channel's tick.
  always_comb begin
    w_raw     = '0;
    w_led_nxt = '0;
    for (int n = 0; n < N_CH; n++) begin
      w_mode_nxt[n]  = r_mode[n];
      w_half_nxt[n]  = r_half[n];
      w_cnt_nxt[n]   = r_cnt[n];
      w_phase_nxt[n] = r_phase[n];
`ifdef LED_BLINK_PWM_EN
      w_duty_nxt[n]  = r_duty[n];
`endif
      if (w_wr_ok && (int'(i_wr_ch) == n)) begin
        w_mode_nxt[n]  = mode_t'(i_wr_mode);
        w_half_nxt[n]  = (i_wr_half == '0) ? PER_W'(1) : i_wr_half;
        w_cnt_nxt[n]   = '0;
        w_phase_nxt[n] = i_wr_mode[1];
`ifdef LED_BLINK_PWM_EN
        w_duty_nxt[n]  = i_wr_duty;
`endif
      end else if (r_tick) begin
        case (r_mode[n])
          MODE_BLINK: begin
            if (r_cnt[n] == r_half[n] - PER_W'(1)) begin
              w_cnt_nxt[n]   = '0;
              w_phase_nxt[n] = ~r_phase[n];
            end else begin
              w_cnt_nxt[n]   = r_cnt[n] + PER_W'(1);
            end
          end
          MODE_ONESHOT: begin
            if (r_cnt[n] == r_half[n] - PER_W'(1)) begin
              w_mode_nxt[n]  = MODE_OFF;
              w_phase_nxt[n] = 1'b0;
              w_cnt_nxt[n]   = '0;
            end else begin
              w_cnt_nxt[n]   = r_cnt[n] + PER_W'(1);
            end
          end
          default: ;
        endcase
      end

      case (r_mode[n])
        MODE_OFF: w_raw[n] = 1'b0;
        MODE_ON:  w_raw[n] = 1'b1;
        default:  w_raw[n] = r_phase[n];
      endcase

`ifdef LED_BLINK_PWM_EN
      w_led_nxt[n] = w_raw[n] & ((r_duty[n] == '1) || (r_pwm_cnt < r_duty[n]));
`else
      w_led_nxt[n] = w_raw[n];
`endif
    end
  end

  // Channel state registers, write ack and registered LED drive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack <= 1'b0;
      r_led <= '0;
      for (int n = 0; n < N_CH; n++) begin
        r_mode[n]  <= MODE_OFF;
        r_half[n]  <= PER_W'(1);
        r_cnt[n]   <= '0;
        r_phase[n] <= 1'b0;
`ifdef LED_BLINK_PWM_EN
        r_duty[n]  <= '0;
`endif
      end
    end else begin
      r_ack <= w_wr_ok;
      r_led <= w_led_nxt;
      for (int n = 0; n < N_CH; n++) begin
        r_mode[n]  <= w_mode_nxt[n];
        r_half[n]  <= w_half_nxt[n];
        r_cnt[n]   <= w_cnt_nxt[n];
        r_phase[n] <= w_phase_nxt[n];
`ifdef LED_BLINK_PWM_EN
        r_duty[n]  <= w_duty_nxt[n];
`endif
      end
    end
  end

  assign o_wr_ack = r_ack;
  assign o_tick   = r_tick;
  assign o_led    = r_led;

endmodule

// File: tb/tb_led_blink_multi.sv
// tb_led_blink_multi: directed plus random checks of led_blink_multi.
// Expected LED levels come from an arithmetic model: for each channel the
// number of prescaler ticks seen since its last write decides the level.
module tb_led_blink_multi;

  localparam int DIV   = 10;
  localparam int N_CH  = 3;
  localparam int PER_W = 8;
  localparam int PWM_W = 4;
  localparam int CH_W  = 2;

  // Clock / reset and DUT signals
  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             wr_en   = 1'b0;
  logic [CH_W-1:0]  wr_ch   = '0;
  logic [1:0]       wr_mode = '0;
  logic [PER_W-1:0] wr_half = '0;
  logic [PWM_W-1:0] wr_duty = '0;
  logic             wr_ack;
  logic             tick;
  logic [N_CH-1:0]  led;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  // Model: current and previous configuration per channel, with write edge.
  int cur_mode [N_CH], cur_half [N_CH], cur_w [N_CH], cur_duty [N_CH];
  int prv_mode [N_CH], prv_half [N_CH], prv_w [N_CH], prv_duty [N_CH];
  int last_ack;

  // Measured run lengths on the LED pins, compared against fixed figures.
  int   run_len [N_CH], hi_run [N_CH], lo_run [N_CH], hi_cnt [N_CH];
  logic last_lvl [N_CH];

  always #5 clk = ~clk;

  // Edge counter: cyc = number of rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  led_blink_multi #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .N_CH   (N_CH),
    .PER_W  (PER_W),
    .PWM_W  (PWM_W)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wr_en  (wr_en),
    .i_wr_ch  (wr_ch),
    .i_wr_mode(wr_mode),
    .i_wr_half(wr_half),
    .i_wr_duty(wr_duty),
    .o_wr_ack (wr_ack),
    .o_tick   (tick),
    .o_led    (led)
  );

  // Ticks consumed by channels at edges 1..m happen at edges 1+k*DIV, k>=1.
  function automatic int ticks_upto(input int m);
    return (m >= 1) ? (m - 1) / DIV : 0;
  endfunction

  // LED seen after edge e reflects channel state after edge e-1.
  function automatic logic [N_CH-1:0] model_led(input int e);
    logic [N_CH-1:0] r;
    int m, md, hf, w, d, n;
    r = '0;
    m = e - 1;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (m >= cur_w[ch]) begin
        md = cur_mode[ch]; hf = cur_half[ch]; w = cur_w[ch]; d = cur_duty[ch];
      end else begin
        md = prv_mode[ch]; hf = prv_half[ch]; w = prv_w[ch]; d = prv_duty[ch];
      end
      n = ticks_upto(m) - ticks_upto(w);
      case (md)
        0:       r[ch] = 1'b0;
        1:       r[ch] = 1'b1;
        2:       r[ch] = ((n / hf) % 2 == 0);
        default: r[ch] = (n < hf);
      endcase
`ifdef LED_BLINK_PWM_EN
      if (m < 0 || !(d == 15 || (m % 16) < d)) r[ch] = 1'b0;
`else
      if (d < 0) r[ch] = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      cur_mode[ch] = 0; cur_half[ch] = 1; cur_w[ch] = 0; cur_duty[ch] = 0;
      prv_mode[ch] = 0; prv_half[ch] = 1; prv_w[ch] = 0; prv_duty[ch] = 0;
      run_len[ch] = 0; hi_run[ch] = 0; lo_run[ch] = 0; hi_cnt[ch] = 0;
      last_lvl[ch] = 1'b0;
    end
    last_ack = -1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  task automatic check_outputs();
    chk("led",  32'(led), 32'(model_led(cyc)));
    chk("tick", 32'(tick), 32'((cyc > 0) && (cyc % DIV == 0)));
    chk("ack",  32'(wr_ack), 32'(cyc == last_ack));
    for (int ch = 0; ch < N_CH; ch++) begin
      if (led[ch] === last_lvl[ch]) begin
        run_len[ch]++;
      end else begin
        if (last_lvl[ch]) hi_run[ch] = run_len[ch];
        else              lo_run[ch] = run_len[ch];
        run_len[ch]  = 1;
        last_lvl[ch] = led[ch];
      end
      if (led[ch] === 1'b1) hi_cnt[ch]++;
    end
  endtask

  // Driver: check the current cycle, then present inputs for the next edge.
  task automatic step(input logic en, input int ch, input int mode, input int half, input int duty);
    @(negedge clk);
    check_outputs();
    wr_en   = en;
    wr_ch   = ch[CH_W-1:0];
    wr_mode = mode[1:0];
    wr_half = half[PER_W-1:0];
    wr_duty = duty[PWM_W-1:0];
    if (en && ch < N_CH) begin
      prv_mode[ch] = cur_mode[ch]; prv_half[ch] = cur_half[ch];
      prv_w[ch]    = cur_w[ch];    prv_duty[ch] = cur_duty[ch];
      cur_mode[ch] = mode;
      cur_half[ch] = (half == 0) ? 1 : half;
      cur_w[ch]    = cyc + 1;
      cur_duty[ch] = duty;
      last_ack     = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();

    // Reset: hold low for 5 clocks and check reset values.
    repeat (5) @(negedge clk);
    chk("rst_led",  32'(led), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_ack",  32'(wr_ack), 32'(0));
    rst_n = 1'b1;
    idle(25);

    // BLINK ch1 half=3: steady 30 high / 30 low.
    step(1'b1, 1, 2, 3, 15);
    idle(130);
    chk("blink_hi_run", 32'(hi_run[1]), 32'(30));
    chk("blink_lo_run", 32'(lo_run[1]), 32'(30));

    // ONESHOT ch0 half=5: one pulse of 41..50 clocks.
    hi_run[0] = 0;
    step(1'b1, 0, 3, 5, 15);
    idle(80);
    n_assert++;
    assert (hi_run[0] >= 41 && hi_run[0] <= 50) else begin
      n_fail++;
      $error("FAIL oneshot_width: observed %0d expected 41..50", hi_run[0]);
    end
    chk("oneshot_off", 32'(led[0]), 32'(0));

    // Rejected write to channel 3: no ack, no change.
    step(1'b1, 3, 1, 1, 15);
    idle(3);

    // Write ch2 BLINK half=2 in the tick cycle; steady high time 20.
    for (int i = 0; i < 2 * DIV && ((cyc + 1) % DIV != 0); i++) idle(1);
    step(1'b1, 2, 2, 2, 15);
    chk("coll_tick", 32'(tick), 32'(1));
    idle(70);
    chk("coll_hi_run", 32'(hi_run[2]), 32'(20));

    // Random writes, including out-of-range channels and half=0.
    for (int k = 0; k < 40; k++) begin
      step(1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 4), $urandom_range(0, 15));
      idle($urandom_range(0, 25));
    end
    idle(60);

`ifdef LED_BLINK_PWM_EN
    // Brightness: duty 4 -> 4 of 16, 15 -> always on, 0 -> dark.
    step(1'b1, 0, 1, 1, 4);
    idle(2);
    hi_cnt[0] = 0;
    idle(16);
    chk("pwm_duty4", 32'(hi_cnt[0]), 32'(4));
    step(1'b1, 0, 1, 1, 15);
    idle(2);
    hi_cnt[0] = 0;
    idle(16);
    chk("pwm_duty15", 32'(hi_cnt[0]), 32'(16));
    step(1'b1, 0, 1, 1, 0);
    idle(2);
    hi_cnt[0] = 0;
    idle(16);
    chk("pwm_duty0", 32'(hi_cnt[0]), 32'(0));
`endif

    // Asynchronous reset between clock edges clears the LEDs at once.
    step(1'b1, 1, 1, 1, 15);
    idle(2);
    chk("pre_rst_led1", 32'(led[1]), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk("async_rst_led", 32'(led), 32'(0));
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    idle(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
